// File: rtl/pwm_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_ctrl
// Brief    : Multi-channel PWM generator. All channels share one period
//            counter. Period and duty values are double-buffered: cfg_wr
//            writes the shadow registers, and the shadow values move into
//            the active registers at the next terminal count.
//            Optional macro PWM_DEADTIME_EN enables complementary low-side
//            outputs with a per-channel dead time of DEAD_CYC clk cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int DEAD_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_wr,
  input  logic [CNT_W-1:0]        period_i,
  input  logic [NUM_CH*CNT_W-1:0] duty_i,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       pwm_p,
  output logic [NUM_CH-1:0]       pwm_n,
  output logic                    cfg_pending,
  output logic                    period_end
);

  logic [CNT_W-1:0]        counter_q,    counter_d;
  logic [CNT_W-1:0]        period_act_q, period_act_d;
  logic [NUM_CH*CNT_W-1:0] duty_act_q,   duty_act_d;
  logic [CNT_W-1:0]        period_sh_q,  period_sh_d;
  logic [NUM_CH*CNT_W-1:0] duty_sh_q,    duty_sh_d;
  logic                    cfg_pending_q, cfg_pending_d;
  logic                    period_end_q,  period_end_d;
  logic [NUM_CH-1:0]       pwm_p_q, pwm_p_d;
  logic [NUM_CH-1:0]       pwm_n_q, pwm_n_d;

  logic                    terminal;
  logic                    period_zero;
  logic                    load;
  logic [NUM_CH-1:0]       raw;

  // Counter, double-buffered configuration and raw channel compare
  always_comb begin
    terminal    = (counter_q == period_act_q);
    period_zero = (period_act_q == '0);
    // A write coincident with the terminal count must not be applied in
    // the same edge; it waits for the following terminal count.
    load        = terminal && cfg_pending_q && !cfg_wr;

    counter_d    = (period_zero || terminal) ? '0 : counter_q + CNT_W'(1);
    period_act_d = load ? period_sh_q : period_act_q;
    duty_act_d   = load ? duty_sh_q   : duty_act_q;
    period_sh_d  = cfg_wr ? period_i : period_sh_q;
    duty_sh_d    = cfg_wr ? duty_i   : duty_sh_q;

    cfg_pending_d = cfg_pending_q;
    if (cfg_wr) begin
      cfg_pending_d = 1'b1;
    end else if (load) begin
      cfg_pending_d = 1'b0;
    end

    period_end_d = terminal && !period_zero;

    raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i] = ch_en[i] && !period_zero &&
               (counter_q < duty_act_q[i*CNT_W +: CNT_W]);
    end
  end

`ifdef PWM_DEADTIME_EN
  // Run length saturates one above DEAD_CYC: an output side may switch on
  // only once the raw level has been stable for more than DEAD_CYC cycles.
  localparam int         RUN_W   = 9;
  localparam logic [8:0] RUN_MAX = 9'(DEAD_CYC + 1);
  localparam logic [8:0] RUN_LIM = 9'(DEAD_CYC);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_deadtime
    logic [RUN_W-1:0] run_q, run_d;
    logic             raw_prev_q;
    logic             p_d, n_d;

    // Count consecutive cycles the raw level has held, gate each side
    always_comb begin
      if (raw[g] == raw_prev_q) begin
        run_d = (run_q == RUN_MAX) ? run_q : run_q + 9'd1;
      end else begin
        run_d = 9'd1;
      end
      p_d = raw[g] && (run_d > RUN_LIM);
      n_d = !raw[g] && ch_en[g] && !period_zero && (run_d > RUN_LIM);
    end

    // Dead-time run-length state
    always_ff @(posedge clk) begin
      if (rst) begin
        run_q      <= '0;
        raw_prev_q <= 1'b0;
      end else begin
        run_q      <= run_d;
        raw_prev_q <= raw[g];
      end
    end

    assign pwm_p_d[g] = p_d;
    assign pwm_n_d[g] = n_d;
  end
`else
  // Without dead time the high side follows raw and the low side is unused.
  assign pwm_p_d = raw;
  assign pwm_n_d = '0;

  // DEAD_CYC has no effect in this build.
  logic unused_dead_cyc;
  assign unused_dead_cyc = ^DEAD_CYC;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q     <= '0;
      period_act_q  <= '0;
      duty_act_q    <= '0;
      period_sh_q   <= '0;
      duty_sh_q     <= '0;
      cfg_pending_q <= 1'b0;
      period_end_q  <= 1'b0;
      pwm_p_q       <= '0;
      pwm_n_q       <= '0;
    end else begin
      counter_q     <= counter_d;
      period_act_q  <= period_act_d;
      duty_act_q    <= duty_act_d;
      period_sh_q   <= period_sh_d;
      duty_sh_q     <= duty_sh_d;
      cfg_pending_q <= cfg_pending_d;
      period_end_q  <= period_end_d;
      pwm_p_q       <= pwm_p_d;
      pwm_n_q       <= pwm_n_d;
    end
  end

  assign pwm_p       = pwm_p_q;
  assign pwm_n       = pwm_n_q;
  assign cfg_pending = cfg_pending_q;
  assign period_end  = period_end_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi_ctrl
// Brief    : Self-checking bench for pwm_multi_ctrl. A cycle model predicts
//            every output; predictions are queued when stimulus is applied
//            and popped and compared after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_ctrl;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 16;
  localparam int DEAD_CYC = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cfg_wr;
  logic [CNT_W-1:0]        period_i;
  logic [NUM_CH*CNT_W-1:0] duty_i;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       pwm_p;
  logic [NUM_CH-1:0]       pwm_n;
  logic                    cfg_pending;
  logic                    period_end;

  pwm_multi_ctrl #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEAD_CYC(DEAD_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_wr     (cfg_wr),
    .period_i   (period_i),
    .duty_i     (duty_i),
    .ch_en      (ch_en),
    .pwm_p      (pwm_p),
    .pwm_n      (pwm_n),
    .cfg_pending(cfg_pending),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] p;
    logic [NUM_CH-1:0] n;
    logic              pend;
    logic              pe;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state (value seen by the DUT in the upcoming cycle)
  int m_cnt, m_per, m_sh_per;
  int m_duty[NUM_CH];
  int m_sh_duty[NUM_CH];
  bit m_pend;
  int m_run[NUM_CH];
  bit m_prev[NUM_CH];

  int hp_cnt;  // pwm_p[0] high cycles in the current window
  int pe_cnt;  // period_end pulses in the current window

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predict outputs for the coming edge and advance the model
  function automatic void model_push();
    exp_t e;
    bit   term, load;
    bit   raw;
    e = '0;
    if (rst) begin
      m_cnt = 0; m_per = 0; m_sh_per = 0; m_pend = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_duty[i] = 0; m_sh_duty[i] = 0; m_run[i] = 0; m_prev[i] = 0;
      end
    end else begin
      term = (m_cnt == m_per);
      for (int i = 0; i < NUM_CH; i++) begin
        raw = ch_en[i] && (m_per != 0) && (m_cnt < m_duty[i]);
`ifdef PWM_DEADTIME_EN
        if (raw == m_prev[i]) m_run[i] = (m_run[i] > DEAD_CYC) ? DEAD_CYC + 1 : m_run[i] + 1;
        else m_run[i] = 1;
        m_prev[i] = raw;
        e.p[i] = raw && (m_run[i] > DEAD_CYC);
        e.n[i] = !raw && ch_en[i] && (m_per != 0) && (m_run[i] > DEAD_CYC);
`else
        e.p[i] = raw;
        e.n[i] = 1'b0;
`endif
      end
      e.pe = term && (m_per != 0);
      load = term && m_pend && !cfg_wr;
      m_cnt = (m_per == 0 || term) ? 0 : m_cnt + 1;
      if (load) begin
        m_per = m_sh_per;
        for (int i = 0; i < NUM_CH; i++) m_duty[i] = m_sh_duty[i];
      end
      if (cfg_wr) begin
        m_sh_per = int'(period_i);
        for (int i = 0; i < NUM_CH; i++) m_sh_duty[i] = int'(duty_i[i*CNT_W +: CNT_W]);
        m_pend = 1'b1;
      end else if (load) begin
        m_pend = 1'b0;
      end
      e.pend = m_pend;
    end
    sb_q.push_back(e);
  endfunction

  task automatic tick();
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_val("pwm_p", 32'(pwm_p), 32'(e.p));
    check_val("pwm_n", 32'(pwm_n), 32'(e.n));
    check_val("cfg_pending", 32'(cfg_pending), 32'(e.pend));
    check_val("period_end", 32'(period_end), 32'(e.pe));
    check_val("overlap", 32'(pwm_p & pwm_n), 32'd0);
    if (pwm_p[0]) hp_cnt++;
    if (period_end) pe_cnt++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic cfg(input int per, input int d0, input int d1, input int d2, input int d3);
    period_i = CNT_W'(per);
    duty_i   = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    cfg_wr   = 1'b1;
    tick();
    cfg_wr   = 1'b0;
  endtask

  // Advance until the model counter reaches the given value (bounded)
  task automatic sync_to(input int target);
    int k;
    k = 0;
    while (m_cnt != target && k < 200) begin
      tick();
      k++;
    end
    if (m_cnt != target) check_val("sync_timeout", 32'(k), 32'd0);
  endtask

  task automatic window(input int n, input int exp_hp, input int exp_pe, input string tag);
    hp_cnt = 0;
    pe_cnt = 0;
    run(n);
    check_val({tag, "_high"}, 32'(hp_cnt), 32'(exp_hp));
    check_val({tag, "_pend"}, 32'(pe_cnt), 32'(exp_pe));
  endtask

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; period_i = '0; duty_i = '0; ch_en = '0;
    hp_cnt = 0; pe_cnt = 0;
    run(3);
    rst = 1'b0;
    run(3);

    // Basic PWM: period 9, duty 3 on channel 0
    ch_en = 4'b0001;
    cfg(9, 3, 0, 0, 0);
    run(5);
    window(20, 6, 2, "basic");

    // Mid-period duty change applies at the next terminal count
    sync_to(4);
    cfg(9, 7, 0, 0, 0);
    run(20);
    window(20, 14, 2, "duty7");

    // Duty 0 never high, duty above period always high
    cfg(9, 0, 0, 0, 0);
    run(15);
    window(20, 0, 2, "duty0");
    cfg(9, 10, 0, 0, 0);
    run(15);
    window(20, 20, 2, "duty_full");

    // Write on the terminal-count cycle, then overwrite while pending
    sync_to(9);
    cfg(9, 2, 0, 0, 0);
    run(3);
    cfg(9, 5, 0, 0, 0);
    run(25);
    window(20, 10, 2, "last_wins");

    // All channels, live enable changes
    ch_en = 4'b1111;
    cfg(9, 2, 4, 6, 10);
    run(25);
    ch_en = 4'b1101;
    run(6);
    ch_en = 4'b1111;
    run(12);

    // Longer period, used for the dead-time shape when enabled
    cfg(19, 10, 0, 5, 19);
    run(45);
`ifdef PWM_DEADTIME_EN
    window(20, 8, 1, "deadtime");
`else
    window(20, 10, 1, "long");
`endif

    // Randomised stretch including period 0
    for (int k = 0; k < 250; k++) begin
      ch_en = NUM_CH'($urandom_range(0, 15));
      if ($urandom_range(0, 14) == 0) begin
        cfg($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 14),
            $urandom_range(0, 14), $urandom_range(0, 14));
      end else begin
        tick();
      end
    end

    // Reset mid-period with a pending write discards everything
    ch_en = 4'b1111;
    cfg(9, 4, 4, 4, 4);
    run(12);
    cfg(9, 8, 8, 8, 8);
    run(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(25);
    check_val("post_rst_p", 32'(pwm_p), 32'd0);
    check_val("post_rst_pend", 32'(cfg_pending), 32'd0);

    // Recovery after reset
    ch_en = 4'b0001;
    cfg(9, 3, 0, 0, 0);
    run(5);
    window(20, 6, 2, "recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
